// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, fetch readiness, and the
// stall/bubble/divider/performance outputs returned to the pipeline.
interface pipe_hazard_ctrl_if;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_users;
    logic        d_usert;
    logic        d_isdiv;
    logic        d_usehilo;
    logic [4:0]  e_rn;
    logic        e_wreg;
    logic        e_m2reg;
    logic        imem_rdy;
    logic        wpcir;
    logic        bubble;
    logic        div_start;
    logic        div_busy;
    logic [15:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_users, d_usert, d_isdiv, d_usehilo,
               e_rn, e_wreg, e_m2reg, imem_rdy,
        input  wpcir, bubble, div_start, div_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_users, d_usert, d_isdiv, d_usehilo,
               e_rn, e_wreg, e_m2reg, imem_rdy,
        output wpcir, bubble, div_start, div_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble generation for the 5-stage pipeline: load-use, fetch wait and
// iterative-divider occupancy, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              clrn,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [15:0]      stall_cnt;

    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic dh;
    logic fw;
    logic stall;
    logic div_start;

    assign rs_hit = bus.d_users & (bus.d_rs == bus.e_rn);
    assign rt_hit = bus.d_usert & (bus.d_rt == bus.e_rn);

    // $zero is never a real producer, so a load targeting it creates no hazard.
    assign lu = bus.e_wreg & bus.e_m2reg & (bus.e_rn != 5'd0) & (rs_hit | rt_hit);
    assign dh = (state == BUSY) & (bus.d_isdiv | bus.d_usehilo);
    assign fw = ~bus.imem_rdy;

    assign stall     = lu | dh | fw;
    assign div_start = bus.d_isdiv & ~stall;

    assign bus.wpcir     = ~stall;
    assign bus.bubble    = stall;
    assign bus.div_start = div_start;
    assign bus.div_busy  = (state == BUSY);
    assign bus.stall_cnt = stall_cnt;

    // The divider counts down independently of pipeline stalls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (div_start) begin
                    cnt_nxt   = CNT_W'(DIV_CYCLES);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DIV_CYCLES = 4): expected per-cycle
// outputs are queued by the stimulus and checked by a negedge monitor.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic clrn;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (6)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        wpcir;
        logic        bubble;
        logic        div_start;
        logic        div_busy;
        logic [15:0] stall_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: one queued expectation is checked per falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (bus.wpcir !== e.wpcir || bus.bubble !== e.bubble ||
                bus.div_start !== e.div_start || bus.div_busy !== e.div_busy ||
                bus.stall_cnt !== e.stall_cnt) begin
                n_bad++;
                $display("FAIL %s: got wpcir=%b bubble=%b div_start=%b div_busy=%b stall_cnt=%h, want wpcir=%b bubble=%b div_start=%b div_busy=%b stall_cnt=%h",
                         e.nm, bus.wpcir, bus.bubble, bus.div_start, bus.div_busy, bus.stall_cnt,
                         e.wpcir, e.bubble, e.div_start, e.div_busy, e.stall_cnt);
            end
        end
    end

    task automatic idle_in();
        bus.d_rs      = 5'd0;
        bus.d_rt      = 5'd0;
        bus.d_users   = 1'b0;
        bus.d_usert   = 1'b0;
        bus.d_isdiv   = 1'b0;
        bus.d_usehilo = 1'b0;
        bus.e_rn      = 5'd0;
        bus.e_wreg    = 1'b0;
        bus.e_m2reg   = 1'b0;
        bus.imem_rdy  = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rn, input logic users, input logic usert);
        bus.e_wreg  = 1'b1;
        bus.e_m2reg = 1'b1;
        bus.e_rn    = rn;
        bus.d_users = users;
        bus.d_rs    = 5'd5;
        bus.d_usert = usert;
        bus.d_rt    = 5'd5;
    endtask

    // Queue the expectation for the current cycle, then move to the next cycle.
    task automatic vec(input string nm, input logic w, input logic b, input logic ds,
                       input logic bz, input logic [15:0] sc);
        exp_t e;
        e.nm = nm; e.wpcir = w; e.bubble = b; e.div_start = ds;
        e.div_busy = bz; e.stall_cnt = sc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0;
        idle_in();
        @(posedge clk);
        #1;
        vec("reset_a", 1, 0, 0, 0, 16'd0);
        vec("reset_b", 1, 0, 0, 0, 16'd0);
        clrn = 1'b1;
        vec("post_reset", 1, 0, 0, 0, 16'd0);

        // Load-use on rs, then the bubble cycle, then non-hazard variants.
        set_lu(5'd5, 1'b1, 1'b0);
        vec("lu_rs", 0, 1, 0, 0, 16'd0);
        idle_in();
        vec("lu_after", 1, 0, 0, 0, 16'd1);
        set_lu(5'd0, 1'b1, 1'b0);
        bus.d_rs = 5'd0;
        vec("lu_rn_zero", 1, 0, 0, 0, 16'd1);
        set_lu(5'd5, 1'b0, 1'b0);
        vec("lu_no_users", 1, 0, 0, 0, 16'd1);
        set_lu(5'd5, 1'b0, 1'b1);
        vec("lu_rt", 0, 1, 0, 0, 16'd1);
        idle_in();
        vec("lu_rt_after", 1, 0, 0, 0, 16'd2);

        // Divide followed by mfhi.
        bus.d_isdiv = 1'b1;
        vec("div0_start", 1, 0, 1, 0, 16'd2);
        idle_in();
        bus.d_usehilo = 1'b1;
        vec("mfhi_c1", 0, 1, 0, 1, 16'd2);
        vec("mfhi_c2", 0, 1, 0, 1, 16'd3);
        vec("mfhi_c3", 0, 1, 0, 1, 16'd4);
        vec("mfhi_c4", 0, 1, 0, 1, 16'd5);
        vec("mfhi_go", 1, 0, 0, 0, 16'd6);
        idle_in();
        vec("div0_idle", 1, 0, 0, 0, 16'd6);

        // Back-to-back divides.
        bus.d_isdiv = 1'b1;
        vec("div1_start", 1, 0, 1, 0, 16'd6);
        vec("div2_c1", 0, 1, 0, 1, 16'd6);
        vec("div2_c2", 0, 1, 0, 1, 16'd7);
        vec("div2_c3", 0, 1, 0, 1, 16'd8);
        vec("div2_c4", 0, 1, 0, 1, 16'd9);
        vec("div2_start", 1, 0, 1, 0, 16'd10);

        // Fetch wait while the second divide runs; one overlapping load-use cycle.
        idle_in();
        vec("fw_busy_c1", 1, 0, 0, 1, 16'd10);
        bus.imem_rdy = 1'b0;
        vec("fw_c2", 0, 1, 0, 1, 16'd10);
        set_lu(5'd5, 1'b1, 1'b0);
        vec("fw_lu_c3", 0, 1, 0, 1, 16'd11);
        idle_in();
        bus.imem_rdy = 1'b0;
        vec("fw_c4", 0, 1, 0, 1, 16'd12);
        bus.imem_rdy = 1'b1;
        vec("fw_done", 1, 0, 0, 0, 16'd13);
        vec("fw_hold", 1, 0, 0, 0, 16'd13);

        // Reset asserted mid-divide clears div_busy without a clock edge.
        bus.d_isdiv = 1'b1;
        vec("div3_start", 1, 0, 1, 0, 16'd13);
        bus.d_isdiv = 1'b0;
        vec("div3_busy", 1, 0, 0, 1, 16'd13);
        clrn = 1'b0;
        vec("async_rst", 1, 0, 0, 0, 16'd0);
        clrn = 1'b1;
        vec("rst_release", 1, 0, 0, 0, 16'd0);

        // Saturation of the stall counter.
        bus.imem_rdy = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        vec("sat_fffe", 0, 1, 0, 0, 16'hFFFE);
        vec("sat_ffff", 0, 1, 0, 0, 16'hFFFF);
        vec("sat_hold1", 0, 1, 0, 0, 16'hFFFF);
        repeat (4500) @(posedge clk);
        #1;
        vec("sat_hold2", 0, 1, 0, 0, 16'hFFFF);
        bus.imem_rdy = 1'b1;
        vec("sat_nostall", 1, 0, 0, 0, 16'hFFFF);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
